// File: rtl/vga_frame_writer.sv
// rtl/vga_frame_writer.sv - serial pixel deserialiser writing tile pixels to video RAM in raster order
module vga_frame_writer #(
   parameter int H_CELLS    = 20,
   parameter int V_CELLS    = 15,
   parameter int PIXEL_BITS = 6,
   parameter int ADDR_W     = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  frame_start,
   input  logic                  serial_in,
   input  logic                  serial_valid,
   input  logic                  wr_ready,
   output logic                  wr_en,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [PIXEL_BITS-1:0] wr_data,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overflow
);
   localparam int XW = (H_CELLS > 1) ? $clog2(H_CELLS) : 1;
   localparam int YW = (V_CELLS > 1) ? $clog2(V_CELLS) : 1;
   localparam int BW = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_CELLS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_CELLS - 1);
   localparam logic [BW-1:0] B_LAST = BW'(PIXEL_BITS - 1);

   typedef enum logic {ST_IDLE, ST_LOAD} state_t;

   state_t                state_q;
   logic [XW-1:0]         x_q;
   logic [YW-1:0]         y_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [BW-1:0]         bit_cnt_q;
   logic [PIXEL_BITS-2:0] shreg_q;
   logic [PIXEL_BITS-1:0] shreg_d;
   logic [PIXEL_BITS-1:0] hold_q;
   logic                  pending_q;
   logic                  busy_q;
   logic                  frame_done_q;
   logic                  overflow_q;

   logic last_tile;
   logic commit;
   logic shift;
   logic word_done;

   // Once the final tile's word is held, further serial bits are ignored.
   always_comb begin
      last_tile = (x_q == X_LAST) && (y_q == Y_LAST);
      commit    = pending_q && wr_ready;
      shift     = serial_valid && !(pending_q && last_tile);
      word_done = shift && (bit_cnt_q == B_LAST);
      shreg_d   = {shreg_q, serial_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         addr_q       <= '0;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         hold_q       <= '0;
         pending_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else if (en) begin
         frame_done_q <= 1'b0;
         if (frame_start) begin
            state_q    <= ST_LOAD;
            busy_q     <= 1'b1;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
         end else if (state_q == ST_LOAD) begin
            if (commit) begin
               pending_q <= 1'b0;
               if (last_tile) begin
                  state_q      <= ST_IDLE;
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
                  addr_q       <= '0;
                  x_q          <= '0;
                  y_q          <= '0;
               end else begin
                  addr_q <= addr_q + 1'b1;
                  if (x_q == X_LAST) begin
                     x_q <= '0;
                     y_q <= y_q + 1'b1;
                  end else begin
                     x_q <= x_q + 1'b1;
                  end
               end
            end
            // A word completing on the write edge refills the holding reg.
            if (shift) begin
               shreg_q <= shreg_d[PIXEL_BITS-2:0];
               if (word_done) begin
                  bit_cnt_q <= '0;
                  if (!pending_q || commit) begin
                     hold_q    <= shreg_d;
                     pending_q <= 1'b1;
                  end else begin
                     overflow_q <= 1'b1;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
         end
      end
   end

   assign wr_en      = commit && en;
   assign wr_addr    = addr_q;
   assign wr_data    = hold_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_vga_frame_writer.sv
// tb/tb_vga_frame_writer.sv - directed and randomized bench for vga_frame_writer with a queue-based frame model
module tb_vga_frame_writer;
   localparam int H     = 4;
   localparam int V     = 2;
   localparam int PB    = 6;
   localparam int AW    = 3;
   localparam int TOTAL = H * V;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          frame_start;
   logic          serial_in;
   logic          serial_valid;
   logic          wr_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [PB-1:0] wr_data;
   logic          busy;
   logic          frame_done;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   bit m_load, m_ovf, m_done;
   int m_bits, m_word, m_hold, m_written;
   int m_pend[$];
   int m_acc[$];

   logic [PB-1:0] mem [TOTAL];
   int n_writes = 0;

   always #5 clk = ~clk;

   vga_frame_writer #(
      .H_CELLS(H), .V_CELLS(V), .PIXEL_BITS(PB), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .frame_start(frame_start),
      .serial_in(serial_in), .serial_valid(serial_valid), .wr_ready(wr_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .frame_done(frame_done), .overflow(overflow)
   );

   // Video RAM stand-in; a restart strobe does not count as a write.
   always @(posedge clk) begin
      if (rst_n && wr_en && !frame_start) begin
         mem[wr_addr] <= wr_data;
         n_writes     <= n_writes + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_load = 0; m_ovf = 0; m_done = 0;
      m_bits = 0; m_word = 0; m_hold = 0; m_written = 0;
      m_pend.delete();
      m_acc.delete();
   endtask

   task automatic model_edge(input bit fs, input bit sv, input bit si, input bit wr, input bit e);
      bit wrote, full;
      int dummy;
      if (!e) return;
      m_done = 0;
      if (fs) begin
         m_load = 1; m_bits = 0; m_word = 0; m_written = 0; m_ovf = 0;
         m_pend.delete();
         m_acc.delete();
         return;
      end
      if (!m_load) return;
      full  = (m_pend.size() > 0) && (m_written == TOTAL - 1);
      wrote = (m_pend.size() > 0) && wr;
      if (wrote) begin
         dummy = m_pend.pop_front();
         m_written++;
         if (m_written == TOTAL) begin
            m_load = 0;
            m_done = 1;
         end
      end
      if (sv && !full) begin
         m_word = ((m_word << 1) | int'(si)) & ((1 << PB) - 1);
         m_bits++;
         if (m_bits == PB) begin
            m_bits = 0;
            if (m_pend.size() == 0) begin
               m_pend.push_back(m_word);
               m_acc.push_back(m_word);
               m_hold = m_word;
            end else begin
               m_ovf = 1;
            end
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_wr_en"}, wr_en, (en && wr_ready && m_pend.size() > 0) ? 1 : 0);
      chk({tag, "_wr_addr"}, wr_addr, (m_written == TOTAL) ? 0 : m_written);
      chk({tag, "_wr_data"}, wr_data, m_hold);
      chk({tag, "_busy"}, busy, m_load);
      chk({tag, "_frame_done"}, frame_done, m_done);
      chk({tag, "_overflow"}, overflow, m_ovf);
   endtask

   task automatic step(input bit fs, input bit sv, input bit si, input bit wr, input bit e, input string tag);
      frame_start = fs; serial_valid = sv; serial_in = si; wr_ready = wr; en = e;
      #1;
      check_outputs(tag);
      model_edge(fs, sv, si, wr, e);
      @(posedge clk);
      #2;
   endtask

   task automatic send_word(input logic [PB-1:0] w, input bit wr_mid, input bit wr_last, input string tag);
      for (int i = PB - 1; i >= 0; i--)
         step(1'b0, 1'b1, w[i], (i == 0) ? wr_last : wr_mid, 1'b1, tag);
   endtask

   task automatic idle(input int n, input bit wr, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, wr, 1'b1, tag);
   endtask

   initial begin
      logic [PB-1:0] words [TOTAL];
      logic [PB-1:0] w, w1, w2;
      int nw;

      rst_n = 1'b0; en = 1'b1; frame_start = 1'b0;
      serial_in = 1'b0; serial_valid = 1'b0; wr_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #2;
      chk("reset_wr_en", wr_en, 0);
      chk("reset_busy", busy, 0);
      chk("reset_wr_data", wr_data, 0);
      rst_n = 1'b1;

      // Single word 101101 written to address 0 the cycle after its last bit.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "t2_fs");
      send_word(6'b101101, 1'b1, 1'b1, "t2");
      chk("t2_wr_en", wr_en, 1);
      chk("t2_addr", wr_addr, 0);
      chk("t2_data", wr_data, 'h2D);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "t2_w");

      // Asynchronous reset while a word is pending.
      send_word(6'h0A, 1'b0, 1'b0, "t1_pend");
      rst_n = 1'b0;
      #1;
      chk("t1_async_wr_en", wr_en, 0);
      chk("t1_async_addr", wr_addr, 0);
      chk("t1_async_data", wr_data, 0);
      chk("t1_async_busy", busy, 0);
      chk("t1_async_done", frame_done, 0);
      chk("t1_async_ovf", overflow, 0);
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Full 4x2 frame.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "t3_fs");
      words[0] = 6'h11;
      for (int i = 1; i < TOTAL; i++) words[i] = PB'($urandom_range(63));
      send_word(words[0], 1'b1, 1'b1, "t3_w0");
      chk("t1_first_addr", wr_addr, 0);
      chk("t1_first_data", wr_data, 'h11);
      for (int i = 1; i < TOTAL; i++) send_word(words[i], 1'b1, 1'b1, "t3");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "t3_last");
      chk("t3_frame_done", frame_done, 1);
      chk("t3_busy_fall", busy, 0);
      chk("t3_addr_wrap", wr_addr, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "t3_after");
      chk("t3_done_pulse", frame_done, 0);
      for (int i = 0; i < TOTAL; i++) chk($sformatf("t3_mem%0d", i), mem[i], words[i]);
      nw = n_writes;
      send_word(PB'($urandom_range(63)), 1'b1, 1'b1, "t3_9th");
      idle(2, 1'b1, "t3_9th_idle");
      chk("t3_no_9th_write", n_writes - nw, 0);

      // Overflow: second word dropped while the first waits for a slot.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "t4_fs");
      send_word(6'h3F, 1'b0, 1'b0, "t4_a");
      send_word(6'h15, 1'b0, 1'b0, "t4_b");
      chk("t4_overflow", overflow, 1);
      chk("t4_held", wr_data, 'h3F);
      nw = n_writes;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "t4_w");
      chk("t4_mem0", mem[0], 'h3F);
      idle(3, 1'b1, "t4_idle");
      chk("t4_one_write", n_writes - nw, 1);
      chk("t4_addr", wr_addr, 1);

      // Enable low mid-word freezes the deserialiser.
      w = 6'h2A;
      for (int i = PB - 1; i >= 3; i--) step(1'b0, 1'b1, w[i], 1'b1, 1'b1, "t5_a");
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 1'b0, "t5_frz");
      for (int i = 2; i >= 0; i--) step(1'b0, 1'b1, w[i], 1'b1, 1'b1, "t5_b");
      chk("t5_data", wr_data, 'h2A);
      chk("t5_addr", wr_addr, 1);
      chk("t5_wr_en", wr_en, 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "t5_w");
      chk("t5_mem1", mem[1], 'h2A);

      // Restart clears overflow and address; same-edge complete+write is not an overflow.
      send_word(6'h01, 1'b0, 1'b0, "t6_o1");
      send_word(6'h02, 1'b0, 1'b0, "t6_o2");
      chk("t6_ovf_set", overflow, 1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "t6_fs1");
      chk("t6_ovf_clr", overflow, 0);
      for (int i = 0; i < 5; i++) send_word(PB'($urandom_range(63)), 1'b1, 1'b1, "t6_5w");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "t6_5w_last");
      chk("t6_addr5", wr_addr, 5);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "t6_fs2");
      chk("t6_addr_restart", wr_addr, 0);
      chk("t6_ovf_restart", overflow, 0);
      w1 = PB'($urandom_range(63));
      w2 = PB'($urandom_range(63));
      send_word(w1, 1'b0, 1'b0, "t6_w1");
      send_word(w2, 1'b0, 1'b1, "t6_w2");
      chk("t6_same_edge_ovf", overflow, 0);
      chk("t6_same_edge_data", wr_data, w2);
      chk("t6_same_edge_addr", wr_addr, 1);
      chk("t6_mem0", mem[0], w1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "t6_w");
      chk("t6_mem1", mem[1], w2);

      // Randomized frames checked cycle by cycle and by final RAM contents.
      for (int f = 0; f < 3; f++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "rnd_fs");
         for (int c = 0; c < 300; c++)
            step(($urandom_range(149) == 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
                 ($urandom_range(1) == 1), ($urandom_range(9) != 0), "rnd");
         for (int i = 0; i < TOTAL && i < m_written; i++)
            chk($sformatf("rnd_mem%0d", i), mem[i], m_acc[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
